pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch-side controller that owns the program counter and sequences instruction-memory requests for the RISC-V core. It selects the next PC from four sources: reset vector, trap vector, branch/jump redirect, or sequential PC+4. It issues one outstanding imem request at a time and buffers the returned instruction for decode with a valid/ready handshake. In-flight fetches made stale by a redirect are killed.

Parameters:
XLEN, 32, PC and instruction width
RESET_VECTOR, 32'h0000_0200, first fetch address after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
io_redirect_valid  input  1  branch/jump taken this cycle
io_redirect_pc  input  XLEN  branch/jump target
io_trap_valid  input  1  trap/exception taken this cycle
io_trap_vec  input  XLEN  trap vector (mtvec)
io_imem_req_valid  output  1  fetch request valid
io_imem_req_ready  input  1  imem accepts request
io_imem_req_addr  output  XLEN  fetch address
io_imem_resp_valid  input  1  fetch data returned (exactly one per accepted request)
io_imem_resp_data  input  XLEN  instruction word
io_inst_valid  output  1  buffered instruction valid to decode
io_inst_ready  input  1  decode consumes instruction
io_inst  output  XLEN  instruction word
io_inst_pc  output  XLEN  PC of io_inst
io_pc_out  output  XLEN  current architectural fetch PC

Behaviour:
- Reset (async, immediate): state=BOOT; pc=RESET_VECTOR; kill=0; io_imem_req_valid=0; io_inst_valid=0; io_inst=0; io_inst_pc=0; io_pc_out=RESET_VECTOR.
- Every loaded target has bits [1:0] forced to 0.
- Redirect priority: trap > redirect > normal sequencing. "Redir" below means (io_trap_valid | io_redirect_valid) with the winning target.
- States:
  - BOOT: lasts 1 cycle after reset deasserts -> REQ. Redir in BOOT loads pc.
  - REQ: req_valid=1, req_addr=pc.
    - ready=1 and no redir -> WAIT.
    - ready=1 with redir: the request is issued with the old pc; pc<=target; kill<=1; -> WAIT.
    - ready=0 with redir: pc<=target; stay REQ; the address changes next cycle.
  - WAIT: req_valid=0.
    - Redir: pc<=target; kill<=1.
    - resp_valid with kill=1 (or redir in the same cycle): discard the response; kill<=0; -> REQ.
    - resp_valid with kill=0 and no redir: io_inst<=resp_data; io_inst_pc<=pc; -> HOLD.
  - HOLD: io_inst_valid=1.
    - inst_ready=1 and no redir: pc<=pc+4 (mod 2^XLEN, wraps 0xFFFF_FFFC->0); -> REQ.
    - Redir (with or without ready): buffer dropped; io_inst_valid=0 next cycle; pc<=target; -> REQ.
- Minimum latency with ready=1 and 1-cycle imem: REQ -> WAIT -> HOLD, so io_inst_valid rises 2 cycles after the request is accepted. Sustained throughput is 1 instruction per 3 cycles.
- io_pc_out = pc register at all times.
- A response in REQ, HOLD or BOOT is a protocol error. It is ignored; an assertion flags it in simulation.
- Reset mid-WAIT: the outstanding response is ignored. The imem side must also be reset by the same signal.

Decomposition:
- Shared package: state enum (BOOT, REQ, WAIT, HOLD), RESET_VECTOR default, XLEN, PC_STEP=4, ALIGN_MASK.
- One combinational sub-module, pc_next_sel: priority mux of trap, redirect and pc+4, with alignment masking.
- FSM, kill flag and instruction buffer stay in pc_sequencer.

Test Plan:
- Reset release, ready=1, 1-cycle resp data 0x00000013, inst_ready=1: first req_addr=0x200; io_inst_pc sequence is 0x200, 0x204, 0x208 with io_inst=0x13.
- Redirect to 0x400 while in WAIT: the response for 0x204 is dropped (no io_inst_valid); next req_addr=0x400; io_inst_pc=0x400.
- Trap (vec 0x100) and redirect (0x400) asserted in the same cycle: pc_out=0x100 and next fetch is 0x100.
- HOLD with inst_ready=0 for 5 cycles: io_inst and io_inst_pc are stable, no new request, pc_out unchanged; on ready, the next req_addr is the old pc+4.
- io_imem_req_ready held 0 for 4 cycles: req_valid stays 1 and req_addr stays 0x200. A redirect to 0x303 during the stall changes req_addr to 0x300.
- Force pc=0xFFFFFFFC via redirect and consume the instruction: next req_addr=0x00000000. Async reset asserted mid-WAIT: outputs return to reset values immediately, and fetch restarts at 0x200.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Pure declarations: no latency, no flow control.
package pc_sequencer_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0200;
    localparam int PC_STEP = 4;
    // Low address bits cleared on every loaded target (word-aligned fetch).
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect, imem request/response and decode-side handshake bundle.
// master = sequencer side; slave = core/imem/decode environment.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic            io_redirect_valid;
    logic [XLEN-1:0] io_redirect_pc;
    logic            io_trap_valid;
    logic [XLEN-1:0] io_trap_vec;
    logic            io_imem_req_valid;
    logic            io_imem_req_ready;
    logic [XLEN-1:0] io_imem_req_addr;
    logic            io_imem_resp_valid;
    logic [XLEN-1:0] io_imem_resp_data;
    logic            io_inst_valid;
    logic            io_inst_ready;
    logic [XLEN-1:0] io_inst;
    logic [XLEN-1:0] io_inst_pc;
    logic [XLEN-1:0] io_pc_out;

    modport master (
        input  io_redirect_valid, io_redirect_pc, io_trap_valid, io_trap_vec,
        input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data, io_inst_ready,
        output io_imem_req_valid, io_imem_req_addr,
        output io_inst_valid, io_inst, io_inst_pc, io_pc_out
    );

    modport slave (
        output io_redirect_valid, io_redirect_pc, io_trap_valid, io_trap_vec,
        output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data, io_inst_ready,
        input  io_imem_req_valid, io_imem_req_addr,
        input  io_inst_valid, io_inst, io_inst_pc, io_pc_out
    );

endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next-PC priority mux (trap > redirect > pc+4) with target alignment.
// Purely combinational; no state, no backpressure.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            redir,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;

    always_comb begin
        raw_target = redirect_pc;
        if (trap_valid) begin
            raw_target = trap_vec;
        end
    end

    assign redir   = trap_valid | redirect_valid;
    assign target  = {raw_target[XLEN-1:2], raw_target[1:0] & ~ALIGN_MASK};
    assign next_pc = redir ? target : pc + XLEN'(PC_STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: one outstanding imem request, one-entry instruction buffer to decode.
// Request accepted -> inst valid 2 cycles later; decode stall holds the buffer and blocks fetch.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic            clock,
    input  logic            reset,
    pc_sequencer_if.master  bus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic            redir;
    logic [XLEN-1:0] next_pc;

    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .pc             (pc_q),
        .trap_valid     (bus.io_trap_valid),
        .trap_vec       (bus.io_trap_vec),
        .redirect_valid (bus.io_redirect_valid),
        .redirect_pc    (bus.io_redirect_pc),
        .redir          (redir),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            ST_BOOT: begin
                if (redir) pc_d = next_pc;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redir) pc_d = next_pc;
                // A redirect in the accept cycle still issues the old pc; its data is killed later.
                if (bus.io_imem_req_ready) begin
                    kill_d  = redir;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir) begin
                    pc_d   = next_pc;
                    kill_d = 1'b1;
                end
                if (bus.io_imem_resp_valid) begin
                    if (kill_q || redir) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = bus.io_imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redir || bus.io_inst_ready) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign bus.io_imem_req_valid = (state_q == ST_REQ);
    assign bus.io_imem_req_addr  = pc_q;
    assign bus.io_inst_valid     = (state_q == ST_HOLD);
    assign bus.io_inst           = inst_q;
    assign bus.io_inst_pc        = inst_pc_q;
    assign bus.io_pc_out         = pc_q;

    resp_only_in_wait: assert property (
        @(posedge clock) disable iff (reset)
        bus.io_imem_resp_valid |-> (state_q == ST_WAIT)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// against a transaction-level fetch model (architectural pc, live fetch, held instruction).
module tb_pc_sequencer;

    logic clock;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;

    logic        r_ready, r_redir, r_trap, r_inst_ready;
    logic [31:0] r_rpc, r_tvec;
    int unsigned lat_cfg;
    bit          lat_rand;
    bit          mem_const;

    // imem environment: one accepted request, answered after a latency
    bit          pend;
    int unsigned pend_cnt;
    logic [31:0] pend_addr;
    bit          resp_now;

    // reference model
    bit          m_boot, m_hold, m_live;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_live_addr;
    int          cyc;

    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] dlv_pc_q[$];
    logic [31:0] dlv_inst_q[$];
    int          dlv_cyc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_const ? 32'h0000_0013 : ((a ^ 32'h5A5A_0013) + 32'h0000_0100);
    endfunction

    task automatic apply_inputs();
        bus.io_imem_req_ready = r_ready;
        bus.io_redirect_valid = r_redir;
        bus.io_redirect_pc    = r_rpc;
        bus.io_trap_valid     = r_trap;
        bus.io_trap_vec       = r_tvec;
        bus.io_inst_ready     = r_inst_ready;
    endtask

    // Applies this cycle's inputs, advances model and imem across the edge, lands on the next negedge.
    task automatic step();
        bit          redir;
        bit          acc;
        bit          n_hold;
        logic [31:0] tgt;
        apply_inputs();
        redir = r_trap | r_redir;
        tgt   = (r_trap ? r_tvec : r_rpc) & 32'hFFFF_FFFC;
        acc   = bus.io_imem_req_valid && r_ready;
        if (bus.io_inst_valid && r_inst_ready && !redir) begin
            dlv_pc_q.push_back(bus.io_inst_pc);
            dlv_inst_q.push_back(bus.io_inst);
            dlv_cyc_q.push_back(cyc);
        end
        if (acc) begin
            acc_q.push_back(bus.io_imem_req_addr);
            acc_cyc_q.push_back(cyc);
        end
        n_hold = m_hold && !redir && !r_inst_ready;
        if (resp_now && m_live && !redir) begin
            n_hold    = 1'b1;
            m_inst    = mem_word(m_live_addr);
            m_inst_pc = m_live_addr;
        end
        if (resp_now || redir) m_live = 1'b0;
        if (acc) begin
            m_live      = !redir;
            m_live_addr = m_pc;
        end
        if (redir) m_pc = tgt;
        else if (m_hold && r_inst_ready) m_pc = m_pc + 32'd4;
        m_hold = n_hold;
        m_boot = 1'b0;
        if (resp_now) pend = 1'b0;
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = (lat_rand ? $urandom_range(1, 3) : lat_cfg) - 1;
            pend_addr = bus.io_imem_req_addr;
        end
        @(negedge clock);
        cyc++;
        resp_now = pend && (pend_cnt == 0);
        bus.io_imem_resp_valid = resp_now;
        bus.io_imem_resp_data  = resp_now ? mem_word(pend_addr) : $urandom();
    endtask

    task automatic model_init();
        m_boot = 1'b1; m_hold = 1'b0; m_live = 1'b0;
        m_pc = 32'h200; m_inst = '0; m_inst_pc = '0; m_live_addr = '0;
        cyc = 0;
        acc_q.delete(); acc_cyc_q.delete();
        dlv_pc_q.delete(); dlv_inst_q.delete(); dlv_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        r_ready = 1'b1; r_redir = 1'b0; r_trap = 1'b0; r_inst_ready = 1'b1;
        r_rpc = '0; r_tvec = '0; lat_cfg = 1; lat_rand = 1'b0; mem_const = 1'b0;
        apply_inputs();
        pend = 1'b0; pend_cnt = 0; resp_now = 1'b0;
        bus.io_imem_resp_valid = 1'b0;
        bus.io_imem_resp_data  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r_ready = 1'b1; r_redir = 1'b0; r_trap = 1'b0; r_inst_ready = 1'b1;
        r_rpc = '0; r_tvec = '0;
        apply_inputs();
        bus.io_imem_resp_valid = 1'b0;
        bus.io_imem_resp_data  = '0;
        @(negedge clock);
        if (bus.io_imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", bus.io_imem_req_valid); end
        n_cmp++;
        if (bus.io_inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", bus.io_inst_valid); end
        n_cmp++;
        if (bus.io_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", bus.io_inst); end
        n_cmp++;
        if (bus.io_inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h want 0", bus.io_inst_pc); end
        n_cmp++;
        if (bus.io_pc_out !== 32'h200) begin n_bad++; $display("FAIL reset_pc_out: got %h want 00000200", bus.io_pc_out); end
        n_cmp++;
    endtask

    task automatic test_sequential();
        do_reset();
        mem_const = 1'b1;
        for (int i = 0; i < 30 && dlv_pc_q.size() < 3; i++) step();
        if (dlv_pc_q.size() < 3 || acc_q.size() < 1) begin
            n_bad++; $display("FAIL seq_timeout: got %0d deliveries want 3", dlv_pc_q.size());
        end else begin
            if (acc_q[0] !== 32'h200) begin n_bad++; $display("FAIL seq_first_addr: got %h want 00000200", acc_q[0]); end
            n_cmp++;
            for (int i = 0; i < 3; i++) begin
                if (dlv_pc_q[i] !== 32'h200 + 32'(4 * i)) begin n_bad++; $display("FAIL seq_inst_pc[%0d]: got %h want %h", i, dlv_pc_q[i], 32'h200 + 32'(4 * i)); end
                n_cmp++;
                if (dlv_inst_q[i] !== 32'h13) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h want 00000013", i, dlv_inst_q[i]); end
                n_cmp++;
            end
            if (dlv_cyc_q[0] - acc_cyc_q[0] != 2) begin n_bad++; $display("FAIL seq_latency: got %0d want 2", dlv_cyc_q[0] - acc_cyc_q[0]); end
            n_cmp++;
            if (dlv_cyc_q[2] - dlv_cyc_q[1] != 3) begin n_bad++; $display("FAIL seq_throughput: got %0d want 3", dlv_cyc_q[2] - dlv_cyc_q[1]); end
            n_cmp++;
        end
    endtask

    task automatic test_redirect_wait();
        bit done;
        do_reset();
        lat_cfg = 3;
        done = 1'b0;
        for (int i = 0; i < 60 && dlv_pc_q.size() < 2; i++) begin
            if (!done && acc_q.size() == 2 && pend) begin
                r_redir = 1'b1; r_rpc = 32'h400; done = 1'b1;
            end else begin
                r_redir = 1'b0;
            end
            step();
        end
        r_redir = 1'b0;
        if (dlv_pc_q.size() < 2 || acc_q.size() < 3) begin
            n_bad++; $display("FAIL redir_timeout: got %0d deliveries want 2", dlv_pc_q.size());
        end else begin
            if (acc_q[1] !== 32'h204) begin n_bad++; $display("FAIL redir_killed_addr: got %h want 00000204", acc_q[1]); end
            n_cmp++;
            if (acc_q[2] !== 32'h400) begin n_bad++; $display("FAIL redir_next_addr: got %h want 00000400", acc_q[2]); end
            n_cmp++;
            if (dlv_pc_q[1] !== 32'h400) begin n_bad++; $display("FAIL redir_inst_pc: got %h want 00000400", dlv_pc_q[1]); end
            n_cmp++;
            if (dlv_inst_q[1] !== mem_word(32'h400)) begin n_bad++; $display("FAIL redir_inst: got %h want %h", dlv_inst_q[1], mem_word(32'h400)); end
            n_cmp++;
        end
    endtask

    task automatic test_trap_priority();
        do_reset();
        r_ready = 1'b0;
        step();
        r_trap = 1'b1; r_tvec = 32'h100; r_redir = 1'b1; r_rpc = 32'h400;
        step();
        r_trap = 1'b0; r_redir = 1'b0;
        if (bus.io_pc_out !== 32'h100) begin n_bad++; $display("FAIL trap_pc_out: got %h want 00000100", bus.io_pc_out); end
        n_cmp++;
        if (bus.io_imem_req_valid !== 1'b1 || bus.io_imem_req_addr !== 32'h100) begin
            n_bad++; $display("FAIL trap_req: got valid=%b addr=%h want valid=1 addr=00000100", bus.io_imem_req_valid, bus.io_imem_req_addr);
        end
        n_cmp++;
        r_ready = 1'b1;
        step();
        if (acc_q.size() != 1 || acc_q[0] !== 32'h100) begin n_bad++; $display("FAIL trap_fetch: got %0d accepts want one at 00000100", acc_q.size()); end
        n_cmp++;
    endtask

    task automatic test_hold_stall();
        logic [31:0] want_inst;
        do_reset();
        r_inst_ready = 1'b0;
        want_inst = mem_word(32'h200);
        for (int i = 0; i < 20 && !bus.io_inst_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            if (bus.io_inst_valid !== 1'b1 || bus.io_inst !== want_inst || bus.io_inst_pc !== 32'h200) begin
                n_bad++; $display("FAIL hold_buffer[%0d]: got v=%b inst=%h pc=%h want v=1 inst=%h pc=00000200", i, bus.io_inst_valid, bus.io_inst, bus.io_inst_pc, want_inst);
            end
            n_cmp++;
            if (bus.io_imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hold_no_req[%0d]: got %b want 0", i, bus.io_imem_req_valid); end
            n_cmp++;
            if (bus.io_pc_out !== 32'h200) begin n_bad++; $display("FAIL hold_pc_out[%0d]: got %h want 00000200", i, bus.io_pc_out); end
            n_cmp++;
            step();
        end
        r_inst_ready = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
        if (acc_q.size() < 2 || acc_q[1] !== 32'h204) begin n_bad++; $display("FAIL hold_next_addr: got %0d accepts want second at 00000204", acc_q.size()); end
        n_cmp++;
    endtask

    task automatic test_req_stall();
        do_reset();
        r_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (bus.io_imem_req_valid !== 1'b1 || bus.io_imem_req_addr !== 32'h200) begin
                n_bad++; $display("FAIL stall_req[%0d]: got valid=%b addr=%h want valid=1 addr=00000200", i, bus.io_imem_req_valid, bus.io_imem_req_addr);
            end
            n_cmp++;
            step();
        end
        r_redir = 1'b1; r_rpc = 32'h303;
        step();
        r_redir = 1'b0;
        if (bus.io_imem_req_valid !== 1'b1 || bus.io_imem_req_addr !== 32'h300) begin
            n_bad++; $display("FAIL stall_redir_addr: got valid=%b addr=%h want valid=1 addr=00000300", bus.io_imem_req_valid, bus.io_imem_req_addr);
        end
        n_cmp++;
        r_ready = 1'b1;
        step();
        if (acc_q.size() != 1 || acc_q[0] !== 32'h300) begin n_bad++; $display("FAIL stall_accept: got %0d accepts want one at 00000300", acc_q.size()); end
        n_cmp++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        r_ready = 1'b0; r_redir = 1'b1; r_rpc = 32'hFFFF_FFFF;
        step();
        r_redir = 1'b0;
        if (bus.io_pc_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc_out: got %h want fffffffc", bus.io_pc_out); end
        n_cmp++;
        r_ready = 1'b1; lat_cfg = 2;
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
        if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0) begin
            n_bad++; $display("FAIL wrap_next_addr: got %0d accepts want fffffffc then 00000000", acc_q.size());
        end
        n_cmp++;
        if (dlv_pc_q.size() != 1 || dlv_pc_q[0] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_inst_pc: got %0d deliveries want one at fffffffc", dlv_pc_q.size()); end
        n_cmp++;
        // Now mid-WAIT for address 0 with its response still pending.
        #2;
        reset = 1'b1;
        pend = 1'b0; resp_now = 1'b0;
        bus.io_imem_resp_valid = 1'b0;
        #1;
        if (bus.io_imem_req_valid !== 1'b0 || bus.io_inst_valid !== 1'b0) begin
            n_bad++; $display("FAIL areset_valids: got req=%b inst=%b want 0 0", bus.io_imem_req_valid, bus.io_inst_valid);
        end
        n_cmp++;
        if (bus.io_inst !== 32'h0 || bus.io_inst_pc !== 32'h0) begin
            n_bad++; $display("FAIL areset_buffer: got inst=%h pc=%h want 0 0", bus.io_inst, bus.io_inst_pc);
        end
        n_cmp++;
        if (bus.io_pc_out !== 32'h200) begin n_bad++; $display("FAIL areset_pc_out: got %h want 00000200", bus.io_pc_out); end
        n_cmp++;
        @(negedge clock);
        reset = 1'b0;
        model_init();
        for (int i = 0; i < 10 && acc_q.size() < 1; i++) step();
        if (acc_q.size() < 1 || acc_q[0] !== 32'h200) begin n_bad++; $display("FAIL areset_restart: got %0d accepts want first at 00000200", acc_q.size()); end
        n_cmp++;
    endtask

    task automatic test_random();
        bit bad;
        do_reset();
        lat_rand = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3000 && !bad; i++) begin
            if (bus.io_imem_req_valid !== (!m_boot && !pend && !m_hold)) begin
                bad = 1'b1; n_bad++; $display("FAIL rnd_req_valid @%0d: got %b want %b", cyc, bus.io_imem_req_valid, !m_boot && !pend && !m_hold);
            end
            n_cmp++;
            if (bus.io_pc_out !== m_pc || (bus.io_imem_req_valid && bus.io_imem_req_addr !== m_pc)) begin
                bad = 1'b1; n_bad++; $display("FAIL rnd_pc @%0d: got pc_out=%h req_addr=%h want %h", cyc, bus.io_pc_out, bus.io_imem_req_addr, m_pc);
            end
            n_cmp++;
            if (bus.io_inst_valid !== m_hold) begin
                bad = 1'b1; n_bad++; $display("FAIL rnd_inst_valid @%0d: got %b want %b", cyc, bus.io_inst_valid, m_hold);
            end
            n_cmp++;
            if (m_hold && (bus.io_inst !== m_inst || bus.io_inst_pc !== m_inst_pc)) begin
                bad = 1'b1; n_bad++; $display("FAIL rnd_inst @%0d: got %h/%h want %h/%h", cyc, bus.io_inst, bus.io_inst_pc, m_inst, m_inst_pc);
            end
            n_cmp++;
            r_ready      = ($urandom_range(0, 3) != 0);
            r_redir      = ($urandom_range(0, 15) == 0);
            r_rpc        = $urandom();
            r_trap       = ($urandom_range(0, 31) == 0);
            r_tvec       = $urandom();
            r_inst_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        if (!bad) begin
            if (dlv_pc_q.size() < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", dlv_pc_q.size()); end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        lat_cfg = 1; lat_rand = 1'b0; mem_const = 1'b0;
        pend = 1'b0; pend_cnt = 0; resp_now = 1'b0; pend_addr = '0;
        model_init();
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_trap_priority();
        test_hold_stall();
        test_req_stall();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before 1000000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
